// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: RV64I opcode constants and instruction format codes
package rv_decode_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;
endpackage

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: classifies instruction format and builds the sign-extended immediate
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [31:0]         instruction,
  output logic [2:0]          format,
  output logic [WORDSIZE-1:0] imm,
  output logic                illegal
);
  logic s;
  fmt_t f;
  assign s = instruction[31];
  assign format = f;
  always_comb begin
    f = FMT_R;
    illegal = 1'b0;
    case (instruction[6:0])
      OP_OP, OP_OP32: f = FMT_R;
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_FENCE, OP_SYSTEM: f = FMT_I;
      OP_STORE: f = FMT_S;
      OP_BRANCH: f = FMT_B;
      OP_LUI, OP_AUIPC: f = FMT_U;
      OP_JAL: f = FMT_J;
      default: illegal = 1'b1;
    endcase
    imm = f == FMT_I ? {{(WORDSIZE-12){s}}, instruction[31:20]} :
          f == FMT_S ? {{(WORDSIZE-12){s}}, instruction[31:25], instruction[11:7]} :
          f == FMT_B ? {{(WORDSIZE-12){s}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0} :
          f == FMT_U ? {{(WORDSIZE-32){s}}, instruction[31:12], 12'b0} :
          f == FMT_J ? {{(WORDSIZE-20){s}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0} :
          '0;
  end
endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV64I decode with valid/ready handshake and one-entry skid buffer
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIZE-1:0]     instruction,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [6:0]          funct7,
  output logic [4:0]          rs2,
  output logic [4:0]          rs1,
  output logic [2:0]          funct3,
  output logic [4:0]          rd,
  output logic [6:0]          op_code,
  output logic [2:0]          format,
  output logic [WORDSIZE-1:0] imm,
  output logic                illegal
);
  localparam int BW = SIZE + 4 + WORDSIZE;
  if (SIZE != 32) begin : g_size
    $error("rv_decode_stage: SIZE must be 32");
  end
  logic [2:0] dfmt;
  logic [WORDSIZE-1:0] dimm;
  logic dill, skid_v, acc, free;
  logic [BW-1:0] dec, out_q, skid_q;
  rv_imm_gen #(.WORDSIZE(WORDSIZE)) u_imm (
    .instruction(instruction),
    .format(dfmt),
    .imm(dimm),
    .illegal(dill)
  );
  // bundle layout: raw instruction bits (fields), format, illegal, immediate
  assign dec = {instruction, dfmt, dill, dimm};
  assign in_ready = !skid_v;
  assign acc = in_valid && in_ready;
  assign free = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      skid_v <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_v <= 1'b0;
    end else if (free) begin
      out_valid <= skid_v || acc;
      skid_v <= 1'b0;
      if (skid_v) out_q <= skid_q;
      else if (acc) out_q <= dec;
    end else if (acc) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end
  assign {funct7, rs2, rs1, funct3, rd, op_code, format, illegal, imm} = out_q;
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered RISC-V (RV64I) decode stage. Splits a raw 32-bit instruction into its fields, classifies the format (R/I/S/B/U/J) and builds the sign-extended immediate at WORDSIZE bits.
- Sits between the fetch output and the register-file/ALU issue logic.
- Uses a valid/ready handshake with a one-entry skid buffer, so backpressure never drops or duplicates an instruction.
- Supports a synchronous flush for branch redirect.

Parameters:
- WORDSIZE, 64, width of the generated immediate (datapath word).
- SIZE, 32, instruction width. Only 32 is supported; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards the output register and skid entry.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept; equals NOT skid_valid.
- instruction  in  SIZE  raw instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- funct7  out  7  instruction[31:25].
- rs2  out  5  instruction[24:20].
- rs1  out  5  instruction[19:15].
- funct3  out  3  instruction[14:12].
- rd  out  5  instruction[11:7].
- op_code  out  7  instruction[6:0].
- format  out  3  R=0, I=1, S=2, B=3, U=4, J=5.
- imm  out  WORDSIZE  sign-extended immediate; 0 for R-format and illegal.
- illegal  out  1  opcode not in the supported set.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0; skid_valid=0, so in_ready=1.
  - All bundle outputs = 0.
- Decode is combinational on the input. The result is captured into the output register or the skid register.
- Latency is 1 cycle: an instruction accepted at edge N appears with out_valid=1 after edge N.
- Accept: in_valid && in_ready. Output register is free when !out_valid || out_ready.
- Accept with output register free: load output register; out_valid=1.
- Accept with output register held (out_valid && !out_ready): load skid; skid_valid=1; in_ready falls next cycle.
- out_valid && out_ready && skid_valid: skid moves to the output register; skid_valid=0.
- out_valid && out_ready, no skid, no accept: out_valid=0.
- Same-cycle out_ready and accept:
  - The skid contents move to the output register first.
  - The new instruction goes to the skid only if the skid was occupied; otherwise it goes straight to the output register.
- Order is strictly FIFO. Skid depth is 1.
- flush has priority over all handshake events:
  - out_valid=0, skid_valid=0.
  - An instruction presented in the same cycle is dropped.
  - in_ready is 1 in the following cycle.
- Bundle outputs hold their value while out_valid=0. They are don't-care to consumers.
- Opcode to format (illegal=0):
  - R: 0110011, 0111011.
  - I: 0000011, 0010011, 0011011, 1100111, 0001111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Anything else: illegal=1, format=0, imm=0. Fields are still extracted.
- Immediates, each sign-extended from bit 31 to WORDSIZE:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- Reset asserted mid-transfer: everything is cleared immediately. No instruction survives.

Decomposition:
- Shared package rv_decode_pkg holds:
  - opcode constants (OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_FENCE, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_OP, OP_OP32);
  - format codes FMT_R..FMT_J.
- One combinational sub-module, rv_imm_gen: inputs instruction; outputs format, imm, illegal. Parameterised by WORDSIZE.
- The top holds the output register, the skid register and the handshake.

Test Plan:
- sd x1,-8(x2) = 32'hFE113C23, out_ready=1 → one cycle later: format=2, rs1=2, rs2=1, funct3=3, imm=64'hFFFF_FFFF_FFFF_FFF8, illegal=0.
- Back-to-back addi x5,x0,1 (32'h00100293), lui x1,0x12345 (32'h123450B7), jal x0,-4 (32'hFFDFF06F):
  - addi → format=1, rd=5, imm=1.
  - lui → format=4, imm=64'h0000_0000_1234_5000.
  - jal → format=5, imm=64'hFFFF_FFFF_FFFF_FFFC.
  - One result per cycle.
- Backpressure: stream A, B, C with out_ready=0 for 3 cycles → A held on output, B in skid, in_ready=0, C held upstream. Then out_ready=1 → A, B, C in order, each exactly once.
- Illegal: 32'h0000007F and 32'h00000000 → illegal=1, format=0, imm=0, op_code=7'h7F and 7'h00 respectively.
- Flush with output and skid full and a new valid input in the same cycle → next cycle out_valid=0, in_ready=1; none of the three instructions ever appears.
- rst_n pulsed low mid-stream, asynchronously between edges → out_valid drops immediately and in_ready=1; after release, decoding resumes cleanly from the next instruction.
